// File: rtl/ddr_pkg.sv
// Shared constants for the pad input conditioner: button indices,
// channel count and the default debounce window.
package ddr_pkg;
   localparam int NUM_BTNS         = 4;
   localparam int BTN_U            = 3;
   localparam int BTN_D            = 2;
   localparam int BTN_L            = 1;
   localparam int BTN_R            = 0;
   // 20 ms at 25 MHz
   localparam int DEBOUNCE_DEFAULT = 500000;
endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stable-sample counter,
// debounced level, frame-consumed press flag and sticky overrun flag.
module btn_debounce
   import ddr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   input  logic frame_tick,
   output logic btn_press,
   output logic btn_level,
   output logic press_overrun
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          accept;
   logic          rise;

   assign differ = (s2 != btn_level);
   assign accept = differ && (cnt == CNT_LAST);
   assign rise   = accept && s2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         cnt           <= '0;
         btn_level     <= 1'b0;
         btn_press     <= 1'b0;
         press_overrun <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         if (!differ || accept)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (accept)
            btn_level <= s2;
         // A new press beats the consumer's clear on the same edge.
         if (rise)
            btn_press <= 1'b1;
         else if (frame_tick)
            btn_press <= 1'b0;
         if (rise && btn_press && !frame_tick)
            press_overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four pad buttons {U, D, L, R} into debounced levels
// and per-frame press events for the game renderer.
module button_conditioner
   import ddr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_raw,
   input  logic                frame_tick,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] press_overrun
);

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_btn_debounce (
         .clk           (clk),
         .reset         (reset),
         .btn_raw       (btn_raw[i]),
         .frame_tick    (frame_tick),
         .btn_press     (btn_press[i]),
         .btn_level     (btn_level[i]),
         .press_overrun (press_overrun[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner with a short
// debounce window, checked against a sliding-window reference model.
module tb_button_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn_raw = 4'b0000;
   logic       frame_tick = 1'b0;
   logic [3:0] btn_press;
   logic [3:0] btn_level;
   logic [3:0] press_overrun;

   int checks = 0;
   int failures = 0;

   // Reference: raw delayed two samples, level flips once the last D
   // synchronized samples all disagree with it.
   logic [3:0]   m_s1, m_s2, m_level, m_press, m_over;
   logic [D-1:0] m_hist [4];

   button_conditioner #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw),
      .frame_tick    (frame_tick),
      .btn_press     (btn_press),
      .btn_level     (btn_level),
      .press_overrun (press_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [3:0] raw, input logic ft, input logic rst_n);
      logic [3:0] rise;
      rise = 4'b0000;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_over = '0;
         for (int ch = 0; ch < 4; ch++) m_hist[ch] = '0;
      end else begin
         for (int ch = 0; ch < 4; ch++) begin
            m_hist[ch] = {m_hist[ch][D-2:0], m_s2[ch]};
            if (m_level[ch] ? (m_hist[ch] == '0) : (&m_hist[ch])) begin
               rise[ch]    = ~m_level[ch];
               m_level[ch] = ~m_level[ch];
            end
            if (rise[ch]) begin
               if (m_press[ch] && !ft) m_over[ch] = 1'b1;
               m_press[ch] = 1'b1;
            end else if (ft) begin
               m_press[ch] = 1'b0;
            end
         end
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   task automatic step(input logic [3:0] raw, input logic ft, input logic rst_n);
      btn_raw    = raw;
      frame_tick = ft;
      reset      = rst_n;
      @(posedge clk);
      model_edge(raw, ft, rst_n);
      #1;
      check4("level", btn_level, m_level);
      check4("press", btn_press, m_press);
      check4("overrun", press_overrun, m_over);
   endtask

   initial begin
      logic [3:0] raw;
      logic       ft;
      logic       rn;

      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_over = '0;
      for (int ch = 0; ch < 4; ch++) m_hist[ch] = '0;

      // Reset state
      step(4'b0101, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      check4("reset_outputs", btn_level | btn_press | press_overrun, 4'b0000);

      // Latency: level and press rise exactly at edge D+2
      for (int i = 1; i <= D + 1; i++) begin
         step(4'b1000, 1'b0, 1'b1);
         check4("latency_early", btn_level | btn_press, 4'b0000);
      end
      step(4'b1000, 1'b0, 1'b1);
      check4("latency_level", btn_level, 4'b1000);
      check4("latency_press", btn_press, 4'b1000);
      step(4'b1000, 1'b1, 1'b1);
      check4("tick_clear", btn_press, 4'b0000);

      // Short glitch on L is ignored
      repeat (3) step(4'b1010, 1'b0, 1'b1);
      repeat (8) step(4'b1000, 1'b0, 1'b1);
      check4("glitch_level", btn_level, 4'b1000);
      check4("glitch_press", btn_press, 4'b0000);
      check4("glitch_overrun", press_overrun, 4'b0000);

      // Pending R press consumed by frame_tick
      repeat (6) step(4'b1001, 1'b0, 1'b1);
      check4("r_pending", btn_press, 4'b0001);
      step(4'b1001, 1'b1, 1'b1);
      check4("r_consumed", btn_press, 4'b0000);
      check4("r_level_kept", btn_level, 4'b1001);

      // D: falling edge keeps press, new rise coinciding with frame_tick wins
      repeat (6) step(4'b1101, 1'b0, 1'b1);
      check4("d_first_press", btn_press, 4'b0100);
      repeat (6) step(4'b1001, 1'b0, 1'b1);
      check4("d_fall_level", btn_level, 4'b1001);
      check4("d_fall_press", btn_press, 4'b0100);
      repeat (5) step(4'b1101, 1'b0, 1'b1);
      step(4'b1101, 1'b1, 1'b1);
      check4("d_tick_rise_press", btn_press, 4'b0100);
      check4("d_tick_rise_overrun", press_overrun, 4'b0000);
      check4("d_tick_rise_level", btn_level, 4'b1101);
      step(4'b1101, 1'b1, 1'b1);

      // U: two presses without a frame_tick set the sticky overrun
      repeat (6) step(4'b0101, 1'b0, 1'b1);
      repeat (6) step(4'b1101, 1'b0, 1'b1);
      check4("u_press1", btn_press, 4'b1000);
      check4("u_press1_overrun", press_overrun, 4'b0000);
      repeat (6) step(4'b0101, 1'b0, 1'b1);
      repeat (6) step(4'b1101, 1'b0, 1'b1);
      check4("u_press2", btn_press, 4'b1000);
      check4("u_press2_overrun", press_overrun, 4'b1000);
      step(4'b1101, 1'b1, 1'b1);
      check4("u_consumed", btn_press, 4'b0000);
      check4("u_overrun_sticky", press_overrun, 4'b1000);

      // Reset mid-debounce discards state; held buttons re-press after release
      repeat (2) step(4'b1111, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 1'b0);
      check4("rst_level", btn_level, 4'b0000);
      check4("rst_press", btn_press, 4'b0000);
      check4("rst_overrun", press_overrun, 4'b0000);
      for (int i = 1; i <= D + 1; i++) begin
         step(4'b1111, 1'b0, 1'b1);
         check4("rst_release_early", btn_press, 4'b0000);
      end
      step(4'b1111, 1'b0, 1'b1);
      check4("rst_release_press", btn_press, 4'b1111);
      check4("rst_release_level", btn_level, 4'b1111);

      // Randomized toggling, frame ticks and occasional reset
      raw = 4'b1111;
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(5) == 0) raw[b] = ~raw[b];
         ft = ($urandom_range(7) == 0);
         rn = ($urandom_range(199) != 0);
         step(raw, ft, rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable synchronized samples required to accept a level change (20 ms at 25 MHz); legal range 2..2^20.
REQ-002 clk  input  1  pixel clock, shared with the game renderer; all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low; clock clk.
REQ-004 btn_raw  input  4  asynchronous pushbutton levels, bit order {U, D, L, R}, active-high.
REQ-005 frame_tick  input  1  one-cycle strobe, high in the single cycle where the renderer is at pixel (0,0).
REQ-006 btn_press  output  4  per-button pending press, bit order as btn_raw, sampled by the renderer on its frame-tick edge.
REQ-007 btn_level  output  4  debounced button level.
REQ-008 press_overrun  output  4  sticky flag: a second press arrived before the first was consumed.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 Per channel, a debounce counter SHALL increment on every edge where s2 != btn_level, and SHALL clear to 0 on any edge where s2 == btn_level.
REQ-011 On an edge where s2 != btn_level and the counter equals DEBOUNCE_CYCLES-1, btn_level SHALL take s2 and the counter SHALL clear.
REQ-012 Latency: for btn_raw changing before edge 1 and held, btn_level SHALL change at edge DEBOUNCE_CYCLES+2, never earlier.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on btn_level, btn_press or press_overrun.
REQ-014 Debounced rising edge (btn_level 0->1): btn_press bit SHALL be set on the same edge that btn_level rises.
REQ-015 Debounced falling edges SHALL NOT affect btn_press.
REQ-016 On an edge where frame_tick=1, every btn_press bit SHALL clear, so each press is visible to the consumer for exactly one frame-tick edge.
REQ-017 Simultaneous rising edge and frame_tick on the same edge: rising edge wins, so btn_press stays 1 for the next frame; press_overrun is not set.
REQ-018 Rising edge while btn_press is already 1 and frame_tick=0: btn_press stays 1 (presses merge) and press_overrun bit SHALL set.
REQ-019 press_overrun SHALL be cleared only by reset.
REQ-020 frame_tick with no pending press SHALL have no effect.
REQ-021 Channels SHALL be fully independent; any combination of simultaneous events on different channels behaves per-channel as above.
REQ-022 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter never wraps.

Reset
REQ-023 While reset=0 at an edge: s1, s2, counters, btn_level, btn_press and press_overrun SHALL all become 0.
REQ-024 Reset asserted mid-debounce or with a pending press SHALL discard that state; no press is reported for it.
REQ-025 A button held high through reset release SHALL be debounced from level 0 and SHALL generate one press at edge DEBOUNCE_CYCLES+2 after release.

Structure
REQ-026 Shared package ddr_pkg SHALL hold the button index constants (BTN_U=3, BTN_D=2, BTN_L=1, BTN_R=0), NUM_BTNS=4 and the default debounce constant.
REQ-027 One sub-module, btn_debounce, SHALL implement a single channel (synchronizer, counter, level, press, overrun) and SHALL be instantiated NUM_BTNS times.
REQ-028 No combinational path from any input to any output; all outputs SHALL be registered.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Hold btn_raw=4'b1000 from edge 1 -> btn_level[3] and btn_press[3] rise at edge 6; other bits stay 0.
REQ-030 Pulse btn_raw[1] high for 3 cycles, then low -> btn_level, btn_press and press_overrun stay 0.
REQ-031 Pending btn_press[0], frame_tick at edge 20 -> btn_press[0] is 1 during that cycle and 0 after edge 20; btn_level[0] is unchanged.
REQ-032 Rising edge on bit 2 at the same edge as frame_tick, with a prior press pending -> btn_press[2] stays 1 after that edge; press_overrun[2]=0.
REQ-033 Two debounced presses on bit 3 with no frame_tick between -> btn_press[3]=1, press_overrun[3]=1; after the next frame_tick btn_press[3]=0 and press_overrun[3] stays 1.
REQ-034 Assert reset for 1 cycle mid-debounce with btn_raw held 4'b1111 -> all outputs 0 after that edge; all four presses appear 6 edges after reset release.
